// File: rtl/sram1rw64x8_pkg.sv
// rtl/sram1rw64x8_pkg.sv - shared types and sizes for the two-port SRAM1RW64x8 arbiter
package sram1rw64x8_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 64;
    localparam int NPORTS = 2;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

endpackage

// File: rtl/sram1rw64x8_arbiter_if.sv
// rtl/sram1rw64x8_arbiter_if.sv - request/response bus between two requesters and the arbiter
interface sram1rw64x8_arbiter_if;
    import sram1rw64x8_pkg::*;

    logic [NPORTS-1:0]        req_valid;
    logic [NPORTS-1:0]        req_ready;
    logic [NPORTS-1:0]        req_we;
    logic [NPORTS*ADDR_W-1:0] req_addr;
    logic [NPORTS*DATA_W-1:0] req_wdata;
    logic                     rsp_valid;
    logic                     rsp_port;
    logic [DATA_W-1:0]        rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_port, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_port, rsp_rdata
    );

endinterface

// File: rtl/sram1rw64x8_arbiter_rr_arbiter2.sv
// rtl/sram1rw64x8_arbiter_rr_arbiter2.sv - two-requester round-robin arbiter, one grant per cycle
module rr_arbiter2 (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       en_i,
    input  logic [1:0] valid_i,
    output logic [1:0] grant_o
);

    logic ptr_q, ptr_d;

    // The pointer only moves on contention, so a lone requester never steals the next turn.
    always_comb begin
        grant_o = 2'b00;
        ptr_d   = ptr_q;
        if (en_i) begin
            case (valid_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11: begin
                    grant_o[ptr_q] = 1'b1;
                    ptr_d          = ~ptr_q;
                end
                default: grant_o = 2'b00;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sram1rw64x8_arbiter.sv
// rtl/sram1rw64x8_arbiter.sv - clears the macro after reset, then shares it round-robin between two ports
module sram1rw64x8_arbiter
    import sram1rw64x8_pkg::*;
#(
    parameter logic [DATA_W-1:0] INIT_VALUE = 8'h00
) (
    input  logic                clock,
    input  logic                reset_n,
    sram1rw64x8_arbiter_if.slave bus,
    output logic                init_done,
    output logic [ADDR_W-1:0]   sram_a,
    output logic [DATA_W-1:0]   sram_i,
    output logic                sram_csb,
    output logic                sram_web,
    output logic                sram_oeb,
    input  logic [DATA_W-1:0]   sram_o
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;
    logic [ADDR_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] i_q, i_d;
    logic              csb_q, csb_d, web_q, web_d, oeb_q, oeb_d;
    logic              rd_v1_q, rd_v1_d, rd_p1_q, rd_p1_d;
    logic              rsp_valid_q, rsp_port_q;

    req_t       req [NPORTS];
    req_t       sel;
    logic [1:0] grant;
    logic       gport;

    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            req[p].we    = bus.req_we[p];
            req[p].addr  = bus.req_addr[p*ADDR_W +: ADDR_W];
            req[p].wdata = bus.req_wdata[p*DATA_W +: DATA_W];
        end
    end

    rr_arbiter2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .en_i    (state_q == RUN),
        .valid_i (bus.req_valid),
        .grant_o (grant)
    );

    assign gport         = grant[1];
    assign sel           = req[gport];
    assign bus.req_ready = grant;

    // Pin registers default to an idle cycle; a and i keep their last value when nothing is issued.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        a_d         = a_q;
        i_d         = i_q;
        csb_d       = 1'b1;
        web_d       = 1'b1;
        oeb_d       = 1'b1;
        rd_v1_d     = 1'b0;
        rd_p1_d     = rd_p1_q;
        case (state_q)
            INIT: begin
                csb_d = 1'b0;
                web_d = 1'b0;
                a_d   = cnt_q;
                i_d   = INIT_VALUE;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end
            end
            RUN: begin
                if (|grant) begin
                    csb_d = 1'b0;
                    a_d   = sel.addr;
                    if (sel.we) begin
                        web_d = 1'b0;
                        i_d   = sel.wdata;
                    end else begin
                        oeb_d   = 1'b0;
                        rd_v1_d = 1'b1;
                        rd_p1_d = gport;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            a_q         <= '0;
            i_q         <= '0;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            oeb_q       <= 1'b1;
            rd_v1_q     <= 1'b0;
            rd_p1_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_port_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
            a_q         <= a_d;
            i_q         <= i_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            oeb_q       <= oeb_d;
            rd_v1_q     <= rd_v1_d;
            rd_p1_q     <= rd_p1_d;
            rsp_valid_q <= rd_v1_q;
            rsp_port_q  <= rd_p1_q;
        end
    end

    assign init_done     = init_done_q;
    assign sram_a        = a_q;
    assign sram_i        = i_q;
    assign sram_csb      = csb_q;
    assign sram_web      = web_q;
    assign sram_oeb      = oeb_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_port  = rsp_port_q;
    assign bus.rsp_rdata = sram_o;

endmodule

// File: doc/sram1rw64x8_arbiter.md
# sram1rw64x8_arbiter

Shares one SRAM1RW64x8 single-port macro between two requesters on the same clock. On every reset it first clears the array to a known value. It then round-robin arbitrates read/write requests from port 0 and port 1 and returns read data tagged with the originating port. It sits directly in front of the macro: it drives A/I/CSB/WEB/OEB from registers, reads O directly, and the macro's CE is tied to the same clock.

## Interface
- INIT_VALUE, 8'h00: word written to all 64 locations during the post-reset sweep.
- clock  in  1  sole clock; also drives macro CE.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-port request valid (bit p = port p).
- req_ready  out  2  per-port request accepted this cycle.
- req_we  in  2  per-port 1 = write, 0 = read.
- req_addr  in  2x6  per-port word address (port p at [6p+5:6p]).
- req_wdata  in  2x8  per-port write data.
- rsp_valid  out  1  read data valid (no backpressure).
- rsp_port  out  1  port that issued the read.
- rsp_rdata  out  8  read data.
- init_done  out  1  high once the clear sweep has finished.
- sram_a  out  6; sram_i  out  8; sram_csb / sram_web / sram_oeb  out  1 each; sram_o  in  8: macro pins.

## Operation
- FSM states: INIT, RUN.
- On reset: state INIT, sweep counter 0.
- INIT:
  - One write per cycle: addr = counter, I = INIT_VALUE, csb = 0, web = 0, oeb = 1.
  - Counter 0..63. After issuing addr 63, go to RUN and set init_done = 1.
  - req_ready = 0 throughout.
- RUN arbitration:
  - One grant per cycle at most.
  - Only one port valid: that port is granted.
  - Both ports valid: grant the port named by rr_ptr, then set rr_ptr to the other port.
  - rr_ptr resets to 0 and updates only when both ports are valid.
  - req_ready[p] = 1 only for the granted port; handshake = valid & ready.
- Accepted write: next cycle drives csb = 0, web = 0, oeb = 1, a = addr, i = wdata.
- Accepted read: next cycle drives csb = 0, web = 1, oeb = 0, a = addr. A 2-stage valid/port pipeline marks the returning data.
- No grant: next cycle drives csb = 1, web = 1, oeb = 1. a and i hold their previous values.
- rsp_rdata = sram_o combinationally. rsp_valid and rsp_port are registered.
- Reset mid-operation: all SRAM controls go idle immediately, in-flight read is dropped, rsp_valid = 0, init_done = 0, and the INIT sweep restarts.

## Timing
- Reset values: req_ready = 0, rsp_valid = 0, rsp_port = 0, init_done = 0, sram_csb = 1, sram_web = 1, sram_oeb = 1, sram_a = 0, sram_i = 0.
- Handshake in cycle c:
  - SRAM pins driven in cycle c+1.
  - Macro samples at the end of c+1.
  - For reads, rsp_valid = 1 with data in cycle c+2. Read latency is 2; throughput is 1 op/cycle.
- INIT lasts exactly 64 cycles after reset release. init_done rises in cycle 65 (the first RUN cycle); req_ready can be 1 in that same cycle.
- Write in c followed by read of the same address in c+1: the read returns the new data. No bypass is needed.
- Back-to-back reads produce rsp_valid on consecutive cycles. There is no response backpressure.

## Structure
- Package sram1rw64x8_pkg:
  - ADDR_W = 6, DATA_W = 8, DEPTH = 64, NPORTS = 2.
  - State enum {INIT, RUN}.
  - Request struct {we, addr, wdata}.
- One sub-module, rr_arbiter2: 2-requester round-robin arbiter holding the rr_ptr flop.
- Top level holds the FSM, sweep counter, pin registers and response pipeline.
- Benches instantiate the real macro model.

## Test plan
- Reset, then idle 70 cycles:
  - init_done rises exactly at cycle 65.
  - Then read all 64 addresses: every rsp_rdata = INIT_VALUE.
- Port 0 writes 8'hA5 to addr 12, then reads addr 12 in the next cycle: rsp_valid two cycles after the read handshake, rsp_port = 0, rsp_rdata = 8'hA5.
- Both ports hold valid for 6 cycles:
  - Grants alternate 0, 1, 0, 1, 0, 1.
  - req_ready is never high on both ports in the same cycle.
- Port 1 alone streams 4 reads of addr 0..3 after writes of 8'h10..8'h13: four consecutive rsp_valid cycles with data 8'h10..8'h13 and rsp_port = 1.
- Assert reset_n low the cycle after a read handshake:
  - No rsp_valid appears.
  - csb = 1 and init_done = 0 during reset.
  - After release, the sweep restarts and 64 INIT writes are observed before req_ready goes high.
- Idle in RUN: sram_csb stays 1 on every cycle with no grant, and no macro write occurs (memory contents unchanged).
